// File: rtl/trace_monitor.sv
// Instruction-trace monitor: captures retired {pc, instr} into a show-ahead FIFO
// while running, halts on a PC breakpoint, and shadows the low architectural registers.
module trace_monitor #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_resume,
  input  logic                         i_clear,
  input  logic                         i_retire_valid,
  input  logic [DATA_W-1:0]            i_retire_pc,
  input  logic [DATA_W-1:0]            i_retire_instr,
  input  logic                         i_wr_en,
  input  logic [4:0]                   i_wr_addr,
  input  logic [DATA_W-1:0]            i_wr_data,
  input  logic                         i_bp_en,
  input  logic [DATA_W-1:0]            i_bp_addr,
  input  logic                         i_tr_ready,
  output logic                         o_tr_valid,
  output logic [DATA_W-1:0]            o_tr_pc,
  output logic [DATA_W-1:0]            o_tr_instr,
  output logic [$clog2(DEPTH):0]       o_tr_count,
  output logic                         o_overflow,
  output logic [15:0]                  o_drop_count,
  output logic                         o_running,
  output logic                         o_halted,
  output logic [31:0]                  o_retire_count,
  output logic [NUM_REGS*DATA_W-1:0]   o_shadow_regs
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t             r_state, w_next;
  logic               r_running, r_halted;
  logic [31:0]        r_retire_count;
  logic [EW-1:0]      r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;
  logic [15:0]        r_drop_count;
  logic [DATA_W-1:0]  r_shadow [NUM_REGS];

  logic               w_capture, w_full, w_pop, w_push, w_drop;
  logic [EW-1:0]      w_head;

  assign w_capture = (r_state == S_RUN) && i_retire_valid;
  assign w_full    = (r_count == CW'(DEPTH));
  // clear wins over any same-cycle push or pop
  assign w_pop     = (r_count != '0) && i_tr_ready && !i_clear;
  assign w_push    = w_capture && !i_clear && (!w_full || w_pop);
  assign w_drop    = w_capture && !i_clear && w_full && !w_pop;
  assign w_head    = r_mem[r_rd_ptr];

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_RUN;
      S_RUN:    if (i_retire_valid && i_bp_en && (i_retire_pc == i_bp_addr)) w_next = S_HALTED;
      S_HALTED: if (i_resume) w_next = S_RUN;
      default:  w_next = S_IDLE;
    endcase
  end

  // state register, registered indicators and retire counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_running      <= 1'b0;
      r_halted       <= 1'b0;
      r_retire_count <= '0;
    end else begin
      r_state   <= w_next;
      r_running <= (w_next == S_RUN);
      r_halted  <= (w_next == S_HALTED);
      if (w_capture) r_retire_count <= r_retire_count + 32'd1;
    end
  end

  // storage array needs no reset; the head is masked while empty
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_retire_pc, i_retire_instr};
  end

  // FIFO pointers, occupancy and drop accounting
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (i_clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  // shadow register file; x0 and out-of-range addresses match no entry
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < int'(NUM_REGS); k++) r_shadow[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_REGS); k++)
        if (i_wr_en && (i_wr_addr == 5'(k + 1))) r_shadow[k] <= i_wr_data;
    end
  end

  always_comb begin
    o_shadow_regs = '0;
    for (int k = 0; k < int'(NUM_REGS); k++)
      o_shadow_regs[k*DATA_W +: DATA_W] = r_shadow[k];
  end

  assign o_tr_valid     = (r_count != '0);
  assign o_tr_pc        = o_tr_valid ? w_head[EW-1:DATA_W] : '0;
  assign o_tr_instr     = o_tr_valid ? w_head[DATA_W-1:0]  : '0;
  assign o_tr_count     = r_count;
  assign o_overflow     = r_overflow;
  assign o_drop_count   = r_drop_count;
  assign o_running      = r_running;
  assign o_halted       = r_halted;
  assign o_retire_count = r_retire_count;

endmodule

// File: tb/tb_trace_monitor.sv
// Directed self-checking bench for trace_monitor with hand-computed expectations.
module tb_trace_monitor;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned DEPTH    = 16;

  logic                       clk = 1'b0;
  logic                       reset, start, resume, clear, retire_valid;
  logic [DATA_W-1:0]          retire_pc, retire_instr, wr_data, bp_addr;
  logic                       wr_en, bp_en, tr_ready;
  logic [4:0]                 wr_addr;
  logic                       tr_valid, overflow, running, halted;
  logic [DATA_W-1:0]          tr_pc, tr_instr;
  logic [4:0]                 tr_count;
  logic [15:0]                drop_count;
  logic [31:0]                retire_count;
  logic [NUM_REGS*DATA_W-1:0] shadow_regs;
  logic [NUM_REGS*DATA_W-1:0] exp_sh;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  trace_monitor #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_resume(resume), .i_clear(clear),
    .i_retire_valid(retire_valid), .i_retire_pc(retire_pc), .i_retire_instr(retire_instr),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_bp_en(bp_en), .i_bp_addr(bp_addr), .i_tr_ready(tr_ready),
    .o_tr_valid(tr_valid), .o_tr_pc(tr_pc), .o_tr_instr(tr_instr), .o_tr_count(tr_count),
    .o_overflow(overflow), .o_drop_count(drop_count), .o_running(running), .o_halted(halted),
    .o_retire_count(retire_count), .o_shadow_regs(shadow_regs)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] instr_of(input logic [DATA_W-1:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic retire(input logic [DATA_W-1:0] pc);
    retire_valid = 1'b1;
    retire_pc    = pc;
    retire_instr = instr_of(pc);
    step();
    retire_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; resume = 0; clear = 0; retire_valid = 0;
    retire_pc = '0; retire_instr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    bp_en = 0; bp_addr = '0; tr_ready = 0;
    #1;
    chk("rst_count", 256'(tr_count), 256'd0);
    chk("rst_valid", 256'(tr_valid), 256'd0);
    chk("rst_pc", 256'(tr_pc), 256'd0);
    chk("rst_running", 256'(running), 256'd0);
    chk("rst_halted", 256'(halted), 256'd0);
    chk("rst_retire_cnt", 256'(retire_count), 256'd0);
    chk("rst_shadow", 256'(shadow_regs), 256'd0);
    step(); step();
    reset = 1'b0;
    step();

    // shadow writes in IDLE: x0 and x9 ignored, x3 updated
    wr_en = 1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; step();
    wr_addr = 5'd3; wr_data = 32'h0000_000A; step();
    wr_addr = 5'd9; wr_data = 32'h1234_5678; step();
    wr_en = 0;
    exp_sh = '0;
    exp_sh[95:64] = 32'h0000_000A;
    chk("shadow_x3", 256'(shadow_regs), 256'(exp_sh));

    // retire ignored while IDLE
    retire(32'h40);
    chk("idle_no_capture", 256'(tr_count), 256'd0);
    chk("idle_no_count", 256'(retire_count), 256'd0);

    pulse_start();
    chk("start_running", 256'(running), 256'd1);

    // basic capture and show-ahead drain
    retire(32'h0); retire(32'h4); retire(32'h8);
    chk("cap3_count", 256'(tr_count), 256'd3);
    chk("cap3_retired", 256'(retire_count), 256'd3);
    chk("cap3_head", 256'(tr_pc), 256'h0);
    chk("cap3_instr", 256'(tr_instr), 256'(32'hA5A5_0000));
    tr_ready = 1; step();
    chk("drain_head4", 256'(tr_pc), 256'h4);
    step();
    chk("drain_head8", 256'(tr_pc), 256'h8);
    step();
    chk("drain_empty", 256'(tr_valid), 256'd0);
    tr_ready = 0;

    // overflow: 20 pushes into 16 entries
    for (int i = 0; i < 20; i++) retire(32'h100 + 32'(4 * i));
    chk("ovf_count", 256'(tr_count), 256'd16);
    chk("ovf_flag", 256'(overflow), 256'd1);
    chk("ovf_drops", 256'(drop_count), 256'd4);
    chk("ovf_head", 256'(tr_pc), 256'h100);
    clear = 1; step(); clear = 0;
    chk("clr_count", 256'(tr_count), 256'd0);
    chk("clr_flag", 256'(overflow), 256'd0);
    chk("clr_drops", 256'(drop_count), 256'd0);
    chk("clr_running", 256'(running), 256'd1);
    chk("clr_retired", 256'(retire_count), 256'd23);

    // simultaneous push and pop while full
    for (int i = 0; i < 16; i++) retire(32'h200 + 32'(4 * i));
    chk("full_count", 256'(tr_count), 256'd16);
    tr_ready = 1; retire(32'h300);
    chk("pp_count", 256'(tr_count), 256'd16);
    chk("pp_no_ovf", 256'(overflow), 256'd0);
    chk("pp_head", 256'(tr_pc), 256'h204);
    for (int i = 0; i < 15; i++) step();
    chk("pp_tail", 256'(tr_pc), 256'h300);
    chk("pp_tail_cnt", 256'(tr_count), 256'd1);
    step();
    tr_ready = 0;
    chk("pp_drained", 256'(tr_valid), 256'd0);
    chk("pp_retired", 256'(retire_count), 256'd40);

    // breakpoint halt at 0x0C
    bp_en = 1; bp_addr = 32'h0C;
    retire(32'h0); retire(32'h4); retire(32'h8);
    chk("bp_pre_halted", 256'(halted), 256'd0);
    retire(32'h0C);
    chk("bp_halted", 256'(halted), 256'd1);
    chk("bp_not_running", 256'(running), 256'd0);
    chk("bp_captured", 256'(tr_count), 256'd4);
    start = 1; step(); start = 0;
    chk("bp_start_ignored", 256'(halted), 256'd1);
    retire(32'h10); retire(32'h14);
    chk("bp_ignored", 256'(tr_count), 256'd4);
    chk("bp_retired", 256'(retire_count), 256'd44);
    bp_en = 0;
    resume = 1; step(); resume = 0;
    chk("resume_running", 256'(running), 256'd1);
    retire(32'h18);
    chk("resume_capture", 256'(tr_count), 256'd5);
    chk("resume_retired", 256'(retire_count), 256'd45);

    // asynchronous reset mid-run with 5 entries queued
    #2 reset = 1'b1;
    #1;
    chk("arst_count", 256'(tr_count), 256'd0);
    chk("arst_valid", 256'(tr_valid), 256'd0);
    chk("arst_running", 256'(running), 256'd0);
    chk("arst_retired", 256'(retire_count), 256'd0);
    chk("arst_shadow", 256'(shadow_regs), 256'd0);
    step();
    reset = 1'b0;
    step();
    retire(32'h20);
    chk("post_rst_idle", 256'(tr_count), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/trace_monitor.md
TRACE_MONITOR -- requirements
Module: trace_monitor

Interface
REQ-001 Parameter DATA_W, 32: width of PC, instruction and register data.
REQ-002 Parameter NUM_REGS, 8: number of shadowed architectural registers, x1..xNUM_REGS; legal range 1..31.
REQ-003 Parameter DEPTH, 16: trace FIFO entries; power of two, at least 2.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 reset  in  1: asynchronous, active-high reset.
REQ-006 start  in  1: one-cycle pulse, IDLE->RUN.
REQ-007 resume  in  1: one-cycle pulse, HALTED->RUN.
REQ-008 clear  in  1: flushes the FIFO, overflow and drop_count.
REQ-009 retire_valid  in  1: the core retired one instruction this cycle.
REQ-010 retire_pc, retire_instr  in  DATA_W each: PC and encoding of the retired instruction.
REQ-011 wr_en  in  1, wr_addr  in  5, wr_data  in  DATA_W: core register-file write port.
REQ-012 bp_en  in  1, bp_addr  in  DATA_W: PC breakpoint enable and address.
REQ-013 tr_ready  in  1: consumer accepts the trace head.
REQ-014 tr_valid  out  1, tr_pc  out  DATA_W, tr_instr  out  DATA_W: FIFO head entry.
REQ-015 tr_count  out  log2(DEPTH)+1: number of occupied FIFO entries.
REQ-016 overflow  out  1: sticky flag, set when an entry has been dropped.
REQ-017 drop_count  out  16: number of dropped entries, saturating.
REQ-018 running  out  1, halted  out  1: state indicators.
REQ-019 retire_count  out  32: instructions retired while in RUN.
REQ-020 shadow_regs  out  NUM_REGS*DATA_W: register xk occupies bits [k*DATA_W-1 : (k-1)*DATA_W].

Function
REQ-021 The state machine SHALL have three states, IDLE, RUN and HALTED; running=1 only in RUN and halted=1 only in HALTED; both are registered.
REQ-022 start SHALL take IDLE->RUN and SHALL be ignored in RUN and HALTED.
REQ-023 resume SHALL take HALTED->RUN and SHALL be ignored in IDLE and RUN.
REQ-024 In RUN, retire_valid=1 is a capture event: push {retire_pc, retire_instr} and increment retire_count (wraps modulo 2^32).
REQ-025 In IDLE or HALTED, retire_valid SHALL be ignored: no push and no count.
REQ-026 In RUN, retire_valid=1 with bp_en=1 and retire_pc==bp_addr SHALL capture the entry AND go to HALTED, with halted=1 in the following cycle.
REQ-027 Shadow writes (wr_en=1, 1<=wr_addr<=NUM_REGS) SHALL update the addressed shadow register at the next edge in every state.
REQ-028 Writes to x0 and to wr_addr>NUM_REGS SHALL be ignored.
REQ-029 FIFO read data SHALL be show-ahead: tr_pc and tr_instr show the head whenever tr_valid=1.
REQ-030 A pop occurs when tr_valid=1 and tr_ready=1.
REQ-031 tr_valid=0 exactly when tr_count=0.
REQ-032 Read and write pointers SHALL wrap modulo DEPTH.
REQ-033 A push when tr_count=DEPTH with no pop in the same cycle SHALL be dropped: FIFO contents unchanged, overflow set to 1, drop_count incremented (saturates at 0xFFFF).
REQ-034 A push and a pop in the same cycle when full SHALL both succeed: tr_count stays at DEPTH, no overflow.
REQ-035 A push and a pop in the same cycle at any other occupancy SHALL leave tr_count unchanged.
REQ-036 clear SHALL empty the FIFO, zero overflow and zero drop_count at the next edge.
REQ-037 clear SHALL take priority over a same-cycle push and pop.
REQ-038 clear SHALL NOT change the FSM state, retire_count or shadow_regs.

Reset
REQ-039 On reset assertion, independent of clk, the block SHALL: enter IDLE; set tr_count=0, tr_valid=0, overflow=0, drop_count=0, retire_count=0 and every shadow register to 0; drive tr_pc and tr_instr to 0.
REQ-040 Reset asserted mid-capture or in HALTED SHALL discard all FIFO contents.
REQ-041 After reset deassertion the block SHALL NOT capture until a start pulse.

Verification
REQ-042 Reset, start, 3 retires (PC 0x0, 0x4, 0x8) with tr_ready=0 -> tr_count=3, retire_count=3, head tr_pc=0x00000000; raise tr_ready -> heads 0x4 then 0x8 on consecutive cycles, then tr_valid=0.
REQ-043 DEPTH=16, tr_ready=0, 20 retires -> tr_count=16, overflow=1, drop_count=4; clear -> tr_count=0, overflow=0, running still 1.
REQ-044 bp_en=1, bp_addr=0x0C, retires at 0x0..0x14 -> halted=1 the cycle after PC 0x0C retires, entry 0x0C is captured, 0x10 and 0x14 are not captured; resume -> running=1 and the next retire is captured.
REQ-045 Full FIFO with tr_ready=1 and a retire in the same cycle -> tr_count stays 16, overflow stays 0, new tail equals the pushed PC.
REQ-046 wr_en with wr_addr=0, data 0xFFFFFFFF, then wr_addr=3, data 0x0000000A, in IDLE -> x3 field = 0x0000000A and all other fields 0; assert reset mid-run with 5 entries queued -> tr_count=0 and state IDLE immediately.
